// File: rtl/pe_spad_pkg.sv
// Shared definitions for the PE scratchpads (ifmap, weight, psum): default
// geometry and the small pointer/depth arithmetic helpers they all use.
package pe_spad_pkg;

    localparam int unsigned SPAD_DATA_WIDTH = 32'd16;
    localparam int unsigned SPAD_MEM_DEPTH  = 32'd16;

    // A requested depth of zero, or one beyond the physical array, means "use it all".
    function automatic int unsigned clamp_depth(input int unsigned depth, input int unsigned mem_depth);
        int unsigned res;
        if ((depth == 32'd0) || (depth > mem_depth)) begin
            res = mem_depth;
        end else begin
            res = depth;
        end
        return res;
    endfunction

    function automatic int unsigned mod_inc(input int unsigned base, input int unsigned inc,
                                            input int unsigned modulus);
        int unsigned sum;
        sum = base + inc;
        if (sum >= modulus) begin
            sum = sum - modulus;
        end else begin
            sum = sum;
        end
        return sum;
    endfunction

endpackage

// File: rtl/spad_regfile.sv
// MEM_DEPTH x DATA_WIDTH storage with one write port and one registered read
// port; a cleared read returns zero and flags it as such.
module spad_regfile
    import pe_spad_pkg::*;
#(
    parameter int unsigned MEM_DEPTH  = SPAD_MEM_DEPTH,
    parameter int unsigned DATA_WIDTH = SPAD_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic                  rclr,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rzero
);

    logic [DATA_WIDTH-1:0] mem_r [MEM_DEPTH];

    // Array contents are deliberately not reset.
    always_ff @(negedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Registered read port; rclr reads suppress the array access entirely.
    always_ff @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata <= {DATA_WIDTH{1'b0}};
            rzero <= 1'b0;
        end else if (re) begin
            if (rclr) begin
                rdata <= {DATA_WIDTH{1'b0}};
                rzero <= 1'b1;
            end else begin
                rdata <= mem_r[raddr];
                rzero <= (mem_r[raddr] == {DATA_WIDTH{1'b0}});
            end
        end
    end

endmodule

// File: rtl/ifmap_window_spad.sv
// Sliding-window ifmap scratchpad: circular buffer with valid/ready writes,
// pointer-only window slides, window-relative reads and sticky error flags.
module ifmap_window_spad
    import pe_spad_pkg::*;
#(
    parameter int unsigned MEM_DEPTH  = SPAD_MEM_DEPTH,
    parameter int unsigned DATA_WIDTH = SPAD_DATA_WIDTH,
    parameter int unsigned MAX_STRIDE = 32'd4,
    parameter int unsigned ADDR_WIDTH = $clog2(MEM_DEPTH),
    parameter int unsigned CNT_WIDTH  = $clog2(MEM_DEPTH + 32'd1),
    parameter int unsigned SH_WIDTH   = $clog2(MAX_STRIDE + 32'd1)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [CNT_WIDTH-1:0]  spad_depth,
    input  logic                  flush,
    input  logic                  w_valid,
    output logic                  w_ready,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic [SH_WIDTH-1:0]   shift_amt,
    input  logic                  r_en,
    input  logic [ADDR_WIDTH-1:0] r_addr,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  r_valid,
    output logic                  dout_zero,
    output logic [CNT_WIDTH-1:0]  count,
    output logic                  full,
    output logic                  empty,
    output logic                  err_ovf,
    output logic                  err_oob
);

    logic [ADDR_WIDTH-1:0] head_r;
    logic [CNT_WIDTH-1:0]  count_r;
    logic                  r_valid_r;
    logic                  err_ovf_r;
    logic                  err_oob_r;

    logic [CNT_WIDTH-1:0]  eff_depth_s;
    logic                  full_s;
    logic                  accept_s;
    logic                  we_s;
    logic [CNT_WIDTH-1:0]  shift_ext_s;
    logic [CNT_WIDTH-1:0]  capped_s;
    logic [CNT_WIDTH-1:0]  eff_s;
    logic                  ovf_s;
    logic                  oob_s;
    logic [ADDR_WIDTH-1:0] tail_s;
    logic [ADDR_WIDTH-1:0] head_next_s;
    logic [ADDR_WIDTH-1:0] rd_idx_s;

    // Status, slide amount and physical addresses, all from pre-edge state.
    always_comb begin
        eff_depth_s = CNT_WIDTH'(clamp_depth(32'(spad_depth), MEM_DEPTH));
        // >= so that a depth lowered below the current fill also stalls writes
        full_s      = (count_r >= eff_depth_s);
        accept_s    = w_valid && !full_s;
        we_s        = accept_s && !flush;
        shift_ext_s = CNT_WIDTH'(shift_amt);
        if (shift_ext_s > CNT_WIDTH'(MAX_STRIDE)) begin
            capped_s = CNT_WIDTH'(MAX_STRIDE);
        end else begin
            capped_s = shift_ext_s;
        end
        if (capped_s > count_r) begin
            eff_s = count_r;
        end else begin
            eff_s = capped_s;
        end
        ovf_s       = (shift_ext_s > eff_s);
        oob_s       = (CNT_WIDTH'(r_addr) >= count_r);
        tail_s      = ADDR_WIDTH'(mod_inc(32'(head_r), 32'(count_r), MEM_DEPTH));
        head_next_s = ADDR_WIDTH'(mod_inc(32'(head_r), 32'(eff_s), MEM_DEPTH));
        rd_idx_s    = ADDR_WIDTH'(mod_inc(32'(head_r), 32'(r_addr), MEM_DEPTH));
    end

    // Window pointers, occupancy and sticky error flags; flush wins over write/slide.
    always_ff @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_r    <= {ADDR_WIDTH{1'b0}};
            count_r   <= {CNT_WIDTH{1'b0}};
            err_ovf_r <= 1'b0;
            err_oob_r <= 1'b0;
        end else if (flush) begin
            head_r    <= {ADDR_WIDTH{1'b0}};
            count_r   <= {CNT_WIDTH{1'b0}};
            err_ovf_r <= 1'b0;
            err_oob_r <= 1'b0;
        end else begin
            head_r  <= head_next_s;
            count_r <= count_r - eff_s + CNT_WIDTH'(accept_s);
            if (ovf_s) begin
                err_ovf_r <= 1'b1;
            end
            if (r_en && oob_s) begin
                err_oob_r <= 1'b1;
            end
        end
    end

    // Read-valid strobe, one cycle per sampled request, flush or not.
    always_ff @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid_r <= 1'b0;
        end else begin
            r_valid_r <= r_en;
        end
    end

    spad_regfile #(
        .MEM_DEPTH (MEM_DEPTH),
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_regfile (
        .clk    (clk),
        .reset_n(reset_n),
        .we     (we_s),
        .waddr  (tail_s),
        .wdata  (din),
        .re     (r_en),
        .rclr   (oob_s),
        .raddr  (rd_idx_s),
        .rdata  (dout),
        .rzero  (dout_zero)
    );

    assign w_ready = !full_s;
    assign full    = full_s;
    assign empty   = (count_r == {CNT_WIDTH{1'b0}});
    assign count   = count_r;
    assign r_valid = r_valid_r;
    assign err_ovf = err_ovf_r;
    assign err_oob = err_oob_r;

endmodule
